mul_i_32: RTL and testbench

Iterative 32x32 multiplier implementing the RV32M multiply group (MUL, MULH, MULHSU, MULHU). It is the companion to the 32-bit iterative divider in the execute stage and resolves one multiplier bit per cycle through shift-add. It sits beside the ALU; the pipeline stalls on `busy` and captures `result` on `done`.

---
 rtl/mul_i_32.sv | 113 +++++++++++
 tb/tb_mul_i_32.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mul_i_32.sv
// Iterative 32x32 RV32M multiplier (MUL/MULH/MULHSU/MULHU): one multiplier bit per
// cycle through unsigned shift-add on operand magnitudes, sign fixed up at the end.
module mul_i_32 (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a_net,
    input  logic [31:0] b_net,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state, state_next;
    logic        load;
    logic [1:0]  op_q;
    logic [31:0] ma, mb;
    logic        neg;
    logic [63:0] p;
    logic [5:0]  cnt;

    logic        sign_a, sign_b;
    logic [31:0] abs_a, abs_b;
    logic [32:0] sum;
    logic [63:0] pf;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    load       = 1'b1;
                end
            end
            RUN: begin
                if (cnt == 6'd31) state_next = FIX;
            end
            FIX: state_next = DONE;
            DONE: begin
                if (start) begin
                    state_next = RUN;
                    load       = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand signs depend on the op; 0x80000000 negates to itself, which is the
    // correct unsigned magnitude.
    always_comb begin
        sign_a = (op != 2'b11) & a_net[31];
        sign_b = (op[1] == 1'b0) & b_net[31];
        abs_a  = sign_a ? (~a_net + 32'd1) : a_net;
        abs_b  = sign_b ? (~b_net + 32'd1) : b_net;
        sum    = {1'b0, p[63:32]} + (mb[0] ? {1'b0, ma} : 33'd0);
        pf     = neg ? (~p + 64'd1) : p;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q   <= '0;
            ma     <= '0;
            mb     <= '0;
            neg    <= 1'b0;
            p      <= '0;
            cnt    <= '0;
            result <= '0;
        end else if (load) begin
            op_q <= op;
            ma   <= abs_a;
            mb   <= abs_b;
            neg  <= sign_a ^ sign_b;
            p    <= '0;
            cnt  <= '0;
        end else if (state == RUN) begin
            // Carry out of the upper-half add becomes the new MSB after the shift.
            p   <= {sum, p[31:1]};
            mb  <= {1'b0, mb[31:1]};
            cnt <= cnt + 6'd1;
        end else if (state == FIX) begin
            result <= (op_q == 2'b00) ? pf[31:0] : pf[63:32];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_next == RUN) || (state_next == FIX);
            done <= (state_next == DONE);
        end
    end

endmodule

// File: tb/tb_mul_i_32.sv
// Self-checking bench for mul_i_32: vector table, randomized ops against an
// arithmetic reference, and hand sequences for ignored start, back-to-back and reset.
module tb_mul_i_32;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a_net, b_net;
    logic        busy, done;
    logic [31:0] result;

    int tests = 0;
    int fails = 0;

    mul_i_32 dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a_net  (a_net),
        .b_net  (b_net),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [64:0] ea, eb, pr;
        ea = (o != 2'b11) ? $signed({{33{a[31]}}, a}) : $signed({33'b0, a});
        eb = (o[1] == 1'b0) ? $signed({{33{b[31]}}, b}) : $signed({33'b0, b});
        pr = ea * eb;
        return (o == 2'b00) ? pr[31:0] : pr[63:32];
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the done cycle (or timeout).
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output int busy_cnt);
        op = o; a_net = a; b_net = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        busy_cnt = 0;
        while (!done && lat < 100) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        if (!done) lat = 999;
        res = result;
    endtask

    initial begin
        logic [31:0] res;
        int lat, bc, ndone, first_lat, second_lat;
        logic [31:0] first_res, second_res;

        vecs[0] = '{"mul_7_m3",      2'b00, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB};
        vecs[1] = '{"mulh_min_min",  2'b01, 32'h80000000, 32'h80000000, 32'h40000000};
        vecs[2] = '{"mulhu_max_max", 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[3] = '{"mul_max_max",   2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
        vecs[4] = '{"mulhsu_m1_max", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[5] = '{"mulhsu_2_min",  2'b10, 32'd2,        32'h80000000, 32'h00000001};
        vecs[6] = '{"mulh_zero",     2'b01, 32'd0,        32'h80000000, 32'h00000000};
        vecs[7] = '{"mul_zero",      2'b00, 32'hFFFFFFFF, 32'd0,        32'h00000000};
        vecs[8] = '{"mulh_m1_m1",    2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
        vecs[9] = '{"mul_min_m1",    2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};

        reset = 1'b1; start = 1'b0; op = '0; a_net = '0; b_net = '0;
        repeat (3) @(negedge clk);
        check("reset_busy",   {31'b0, busy}, 32'd0);
        check("reset_done",   {31'b0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // first vector also checks latency and busy duration
        do_op(vecs[0].op, vecs[0].a, vecs[0].b, res, lat, bc);
        check("first_latency", lat, 32'd33);
        check("first_busy_cycles", bc, 32'd33);
        check("first_busy_low_at_done", {31'b0, busy}, 32'd0);
        check(vecs[0].name, res, vecs[0].exp);
        @(negedge clk);
        check("done_one_cycle", {31'b0, done}, 32'd0);
        check("result_held", result, vecs[0].exp);

        for (int i = 1; i < 10; i++) begin
            @(negedge clk);
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, bc);
            check({vecs[i].name, "_lat"}, lat, 32'd33);
            check(vecs[i].name, res, vecs[i].exp);
            check({vecs[i].name, "_model"}, vecs[i].exp, model(vecs[i].op, vecs[i].a, vecs[i].b));
        end

        for (int i = 0; i < 24; i++) begin
            logic [1:0] o;
            logic [31:0] a, b;
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            if (i % 6 == 0) a = 32'h80000000;
            if (i % 7 == 3) b = 32'hFFFFFFFF;
            if (i % 8 == 5) a = 32'd0;
            @(negedge clk);
            do_op(o, a, b, res, lat, bc);
            check("rand_lat", lat, 32'd33);
            check("rand_result", res, model(o, a, b));
        end

        // start while busy is ignored; start in DONE chains back-to-back
        @(negedge clk);
        op = 2'b00; a_net = 32'd5; b_net = 32'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0; first_lat = -1; second_lat = -1; first_res = '0; second_res = '0;
        for (int c = 0; c < 110; c++) begin
            if (c == 10) begin
                op = 2'b00; a_net = 32'd9; b_net = 32'd9; start = 1'b1;
            end else if (done) begin
                ndone++;
                if (ndone == 1) begin
                    first_lat = c; first_res = result;
                    op = 2'b00; a_net = 32'd3; b_net = 32'd4; start = 1'b1;
                end else if (ndone == 2) begin
                    second_lat = c; second_res = result;
                end
            end
            @(negedge clk);
            start = 1'b0;
        end
        check("ignore_start_lat", first_lat, 32'd33);
        check("ignore_start_result", first_res, 32'h1E);
        check("b2b_lat", second_lat, 32'd67);
        check("b2b_result", second_res, 32'd12);
        check("done_pulse_count", ndone, 32'd2);

        // reset mid-operation
        op = 2'b11; a_net = 32'hFFFFFFFF; b_net = 32'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_busy",   {31'b0, busy}, 32'd0);
        check("midreset_done",   {31'b0, done}, 32'd0);
        check("midreset_result", result, 32'd0);
        ndone = 0;
        for (int c = 0; c < 50; c++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("midreset_no_done", ndone, 32'd0);
        do_op(2'b11, 32'hFFFFFFFF, 32'd2, res, lat, bc);
        check("after_reset_lat", lat, 32'd33);
        check("after_reset_result", res, 32'h00000001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
